// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared types and constants for the ysyx_24100005 load/store memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_24100005_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE_DEF = 32'h0800_0000;

  // Wide enough for the largest legal LATENCY-1 (14).
  localparam int CNT_W = 4;

  // Unsigned window test; the subtraction form avoids overflow of base+size.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/ysyx_24100005_lat_cnt.sv
// Loadable down-counter that flags when it reaches 1 (last wait cycle).
// Latency: load/decrement take effect on the next rising edge; done is combinational from the count.
// Backpressure: none; dec is simply ignored once the count is 0.
// Ports: clk, rst_n (async active-low clear), load/load_val, dec, done.
module ysyx_24100005_lat_cnt
  import ysyx_24100005_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ysyx_24100005_sram.sv
// Single-outstanding memory responder: accept a request, wait LATENCY cycles, access the memory model.
// Latency: rsp_valid rises LATENCY edges after the edge preceding the accepting cycle; occupancy LATENCY+1.
// Backpressure: response (and memory side effect) held until rsp_ready; req_ready low outside IDLE.
// Ports: clk, rst (async active-low), req_{valid,ready,wen,addr,wdata,wmask}, rsp_{valid,ready,rdata,err}.

// Compilation-unit memory model with the same call signatures as the core's
// npcmem DPI imports, so the responder elaborates without the C side. It keeps
// call counters and the last address/mask so callers can observe the accesses.
int          npcmem_rd_cnt;
int          npcmem_wr_cnt;
logic [31:0] npcmem_last_addr;
logic [7:0]  npcmem_last_wmask;
logic [31:0] npcmem_words [4096];

function automatic int npcmem_read(input int raddr);
  logic [11:0] idx;
  idx              = raddr[13:2];
  npcmem_rd_cnt    = npcmem_rd_cnt + 1;
  npcmem_last_addr = raddr;
  return npcmem_words[idx];
endfunction

function automatic void npcmem_write(input int waddr, input int wdata, input byte wmask);
  logic [11:0] idx;
  logic [31:0] w;
  idx               = waddr[13:2];
  npcmem_wr_cnt     = npcmem_wr_cnt + 1;
  npcmem_last_addr  = waddr;
  npcmem_last_wmask = wmask;
  w = npcmem_words[idx];
  for (int b = 0; b < 4; b++) begin
    if (wmask[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
  end
  npcmem_words[idx] = w;
endfunction

module ysyx_24100005_sram
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
  parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e      state_q, state_d;
  logic        live_q;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, rsp_hs, enter_resp, cnt_done;
  logic        act_wen;
  logic [31:0] act_addr, act_wdata;
  logic [3:0]  act_wmask;
  logic        wmask_hi_unused;

  // Upper mask bits are defined as don't-care on this port.
  assign wmask_hi_unused = ^req_wmask[7:4];

  // live_q keeps req_ready low during reset and until the first edge after release.
  assign req_ready  = live_q && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign enter_resp = (state_q != RESP) && (state_d == RESP);

  // With LATENCY==1 the access happens on the accepting edge, before the
  // latch is loaded, so the live request fields are forwarded in IDLE.
  always_comb begin
    act_wen   = wen_q;
    act_addr  = addr_q;
    act_wdata = wdata_q;
    act_wmask = wmask_q;
    if (state_q == IDLE) begin
      act_wen   = req_wen;
      act_addr  = req_addr;
      act_wdata = req_wdata;
      act_wmask = req_wmask[3:0];
    end
  end

  ysyx_24100005_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (accept),
    .load_val (LAT_M1),
    .dec      (state_q == WAIT),
    .done     (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (cnt_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask[3:0];
      end
      // The memory side effect happens only on the edge that raises rsp_valid,
      // so a reset during WAIT cancels it and a stalled response never repeats it.
      if (enter_resp) begin
        if (!addr_in_range(act_addr, MEM_BASE, MEM_SIZE)) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else if (act_wen) begin
          npcmem_write(act_addr & ~32'h3, act_wdata, {4'b0, act_wmask});
          err_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          err_q   <= 1'b0;
          rdata_q <= npcmem_read(act_addr & ~32'h3);
        end
      end else if (rsp_hs) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_sram.sv
// Directed bench for ysyx_24100005_sram with three instances at LATENCY 1, 3 and 4.
// Latency: measured in edges from the edge preceding the accepting cycle.
// Backpressure: exercised by holding rsp_ready low on the LATENCY=1 instance.
module tb_ysyx_24100005_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wen   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [7:0]  req_wmask [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24100005_sram #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  ysyx_24100005_sram #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  ysyx_24100005_sram #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  // Present one request, wait for its acceptance and then for rsp_valid.
  // Returns with rsp_valid high (unless a budget ran out) and the response
  // not yet handshaken. lat counts edges from the edge before the accept cycle.
  task automatic send_wait(input int d, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [7:0] wmask,
                           output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = wmask;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
  endtask

  // Full transaction with rsp_ready already high: one more edge completes the handshake.
  task automatic xact(input int d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [7:0] wmask,
                      output logic [31:0] rdata, output logic err, output int lat);
    send_wait(d, wen, addr, wdata, wmask, rdata, err, lat);
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        er;
    int          lt;
    xact(0, 1'b1, addr, data, 8'h0F, rd, er, lt);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wmask[d] = '0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b rdata=%h err=%b, required 0/0/00000000/0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b, required 0", req_ready[0]);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_release[%0d]: got %b, required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_read_l1();
    logic [31:0] rd;
    logic        er;
    int          lt, r0;
    preload(32'h8000_0010, 32'hDEAD_BEEF);
    r0 = npcmem_rd_cnt;
    xact(0, 1'b0, 32'h8000_0012, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (lt !== 1 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL read_l1: lat=%0d rdata=%h err=%b, required 1/deadbeef/0", lt, rd, er);
    end
    checks++;
    if (npcmem_rd_cnt - r0 !== 1 || npcmem_last_addr !== 32'h8000_0010) begin
      failures++;
      $display("FAIL read_l1_call: calls=%0d addr=%h, required 1/80000010", npcmem_rd_cnt - r0, npcmem_last_addr);
    end
  endtask

  task automatic test_masked_write_l3();
    logic [31:0] rd;
    logic        er;
    int          lt, w0;
    preload(32'h8000_0020, 32'hAAAA_AAAA);
    preload(32'h8000_0024, 32'h5566_7788);
    w0 = npcmem_wr_cnt;
    xact(1, 1'b1, 32'h8000_0020, 32'h1122_3344, 8'h03, rd, er, lt);
    checks++;
    if (lt !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL write_l3: lat=%0d rdata=%h err=%b, required 3/00000000/0", lt, rd, er);
    end
    checks++;
    if (npcmem_wr_cnt - w0 !== 1 || npcmem_last_wmask !== 8'h03) begin
      failures++;
      $display("FAIL write_l3_call: calls=%0d wmask=%h, required 1/03", npcmem_wr_cnt - w0, npcmem_last_wmask);
    end
    xact(1, 1'b0, 32'h8000_0020, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (lt !== 3 || rd !== 32'hAAAA_3344) begin
      failures++;
      $display("FAIL readback_l3: lat=%0d rdata=%h, required 3/aaaa3344", lt, rd);
    end
    // Only upper mask bits set: the write still happens, passes a zero mask, changes nothing.
    w0 = npcmem_wr_cnt;
    xact(1, 1'b1, 32'h8000_0024, 32'hFFFF_FFFF, 8'hF0, rd, er, lt);
    checks++;
    if (npcmem_wr_cnt - w0 !== 1 || npcmem_last_wmask !== 8'h00 || er !== 1'b0) begin
      failures++;
      $display("FAIL zero_mask_write: calls=%0d wmask=%h err=%b, required 1/00/0", npcmem_wr_cnt - w0, npcmem_last_wmask, er);
    end
    xact(1, 1'b0, 32'h8000_0024, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (rd !== 32'h5566_7788) begin
      failures++;
      $display("FAIL zero_mask_readback: got %h, required 55667788", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lt, r0;
    rsp_ready[0] = 1'b0;
    r0 = npcmem_rd_cnt;
    send_wait(0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (lt !== 1 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL bp_first: lat=%0d rdata=%h err=%b, required 1/deadbeef/0", lt, rd, er);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1/deadbeef/0/0",
                 c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
      end
    end
    checks++;
    if (npcmem_rd_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL bp_calls: got %0d, required 1", npcmem_rd_cnt - r0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0/1", rsp_valid[0], req_ready[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic        er;
    int          lt, r0, w0;
    preload(32'h8000_0000, 32'h0BAD_F00D);
    r0 = npcmem_rd_cnt;
    xact(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || npcmem_rd_cnt !== r0) begin
      failures++;
      $display("FAIL oor_read: err=%b rdata=%h calls=%0d, required 1/00000000/0", er, rd, npcmem_rd_cnt - r0);
    end
    w0 = npcmem_wr_cnt;
    xact(0, 1'b1, 32'h8800_0000, 32'h1234_5678, 8'h0F, rd, er, lt);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || npcmem_wr_cnt !== w0) begin
      failures++;
      $display("FAIL oor_write: err=%b rdata=%h calls=%0d, required 1/00000000/0", er, rd, npcmem_wr_cnt - w0);
    end
    xact(0, 1'b0, 32'h87FF_FFFC, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (er !== 1'b0) begin
      failures++;
      $display("FAIL top_word_in_range: err=%b, required 0", er);
    end
    xact(0, 1'b0, 32'h8000_0000, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL oor_mem_unchanged: err=%b rdata=%h, required 0/0badf00d", er, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lt, w0, n;
    logic        saw;
    preload(32'h8000_0030, 32'hCAFE_F00D);
    w0 = npcmem_wr_cnt;
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0030;
    req_wdata[2] = 32'h0;  req_wmask[2] = 8'h0F;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_immediate: valid=%b ready=%b, required 0/0", rsp_valid[2], req_ready[2]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ready_early: got %b, required 0", req_ready[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready[2] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_ready: got %b, required 1", req_ready[2]);
    end
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[2] !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || npcmem_wr_cnt !== w0) begin
      failures++;
      $display("FAIL rst_mid_discard: stray_rsp=%b writes=%0d, required 0/0", saw, npcmem_wr_cnt - w0);
    end
    xact(2, 1'b0, 32'h8000_0030, 32'h0, 8'h0, rd, er, lt);
    checks++;
    if (lt !== 4 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_mem: lat=%0d rdata=%h err=%b, required 4/cafef00d/0", lt, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic        acc, hs;
    logic [31:0] cap;
    int          k, r, last;
    addrs[0] = 32'h8000_0040; datas[0] = 32'h0101_0101;
    addrs[1] = 32'h8000_0044; datas[1] = 32'h0202_0202;
    addrs[2] = 32'h8000_0048; datas[2] = 32'h0303_0303;
    for (int i = 0; i < 3; i++) preload(addrs[i], datas[i]);
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = addrs[0];
    k = 0; r = 0; last = -2;
    for (int c = 0; c < 20 && r < 3; c++) begin
      acc = req_valid[0] && req_ready[0];
      hs  = rsp_valid[0] && rsp_ready[0];
      cap = rsp_rdata[0];
      if (hs) begin
        checks++;
        if (cap !== datas[r] || req_ready[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rsp[%0d]: rdata=%h ready=%b, required %h/0", r, cap, req_ready[0], datas[r]);
        end
      end
      @(posedge clk); #1;
      if (hs) r++;
      if (acc) begin
        if (k > 0) begin
          checks++;
          if (c - last !== 2) begin
            failures++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 2", k, c - last);
          end
        end
        last = c;
        k++;
        if (k < 3) req_addr[0] = addrs[k];
        else       req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    checks++;
    if (r !== 3 || k !== 3) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d responses=%0d, required 3/3", k, r);
    end
  endtask

  initial begin
    test_reset();
    test_read_l1();
    test_masked_write_l3();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
